// File: rtl/lsu_mem_initiator_if.sv
// Request/response and data-memory signals of the load/store initiator.
// The master modport is the initiator itself; slave is the pipeline plus memory side.
interface lsu_mem_initiator_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic        mem_w_enable;
    logic [1:0]  mem_access_size;
    logic        mem_rdun;
    logic [31:0] mem_data_out;

    modport master (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  mem_data_out,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_address, mem_data_in, mem_w_enable, mem_access_size, mem_rdun
    );

    modport slave (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output mem_data_out,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_address, mem_data_in, mem_w_enable, mem_access_size, mem_rdun
    );
endinterface

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator: range check, aligned single access or byte-beat split, 1-cycle response.
// Define MISALIGN_TRAP_EN to reject misaligned requests instead of splitting them.
module lsu_mem_initiator #(
    parameter logic [31:0] START_ADDRESS = 32'h0100_0000,
    parameter logic [31:0] MEM_SIZE      = 32'h0010_0000
) (
    input logic           clk,
    input logic           reset,
    lsu_mem_initiator_if.master bus
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
`ifndef MISALIGN_TRAP_EN
        SPLIT,
`endif
        DONE
    } state_e;

    state_e      state_q;
    logic        write_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic        req_ready_q;
    logic        resp_valid_q;
    logic        resp_err_q;
    logic [31:0] resp_rdata_q;
    logic [31:0] mem_address_q;
    logic [31:0] mem_data_in_q;
    logic        mem_w_enable_q;
    logic [1:0]  mem_access_size_q;
    logic        mem_rdun_q;
`ifndef MISALIGN_TRAP_EN
    logic [1:0]  beat_q;
    logic [31:0] wdata_q;
    logic [31:0] result_q;
    logic [31:0] split_merged;
    logic [1:0]  split_last;
`endif

    logic [2:0]  req_nbytes;
    logic [32:0] req_last;
    logic [32:0] win_end;
    logic        req_range_err;
    logic        req_misaligned;
    logic        req_reject;

    function automatic logic [31:0] extend_load(input logic [31:0] raw, input logic [1:0] size,
                                                input logic uns);
        case (size)
            2'b00:   return uns ? {24'b0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
            2'b01:   return uns ? {16'b0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    // NOTE: combinational blocks assign every output first so no path leaves a latch behind.
    always_comb begin
        req_nbytes = 3'd4;
        if (bus.req_size == 2'b00) req_nbytes = 3'd1;
        else if (bus.req_size == 2'b01) req_nbytes = 3'd2;
        // 33-bit sums so a request near the top of the address space cannot wrap into range
        req_last       = {1'b0, bus.req_addr} + {30'b0, req_nbytes} - 33'd1;
        win_end        = {1'b0, START_ADDRESS} + {1'b0, MEM_SIZE};
        req_range_err  = (bus.req_addr < START_ADDRESS) || (req_last >= win_end);
        req_misaligned = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                         (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00));
`ifdef MISALIGN_TRAP_EN
        req_reject     = req_range_err || req_misaligned;
`else
        req_reject     = req_range_err;
`endif
    end

`ifndef MISALIGN_TRAP_EN
    always_comb begin
        split_merged = result_q;
        split_merged[{beat_q, 3'b000} +: 8] = bus.mem_data_out[7:0];
        split_last   = (size_q == 2'b01) ? 2'd1 : 2'd3;
    end
`endif

    // NOTE: all state and registered outputs update with non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q           <= IDLE;
            write_q           <= 1'b0;
            size_q            <= 2'b00;
            unsigned_q        <= 1'b0;
            req_ready_q       <= 1'b1;
            resp_valid_q      <= 1'b0;
            resp_err_q        <= 1'b0;
            resp_rdata_q      <= '0;
            mem_address_q     <= '0;
            mem_data_in_q     <= '0;
            mem_w_enable_q    <= 1'b0;
            mem_access_size_q <= 2'b00;
            mem_rdun_q        <= 1'b0;
`ifndef MISALIGN_TRAP_EN
            beat_q            <= 2'd0;
            wdata_q           <= '0;
            result_q          <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        write_q     <= bus.req_write;
                        size_q      <= bus.req_size;
                        unsigned_q  <= bus.req_unsigned;
                        req_ready_q <= 1'b0;
                        if (req_reject) begin
                            state_q      <= DONE;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                        end else if (!req_misaligned) begin
                            state_q           <= ACCESS;
                            mem_address_q     <= bus.req_addr;
                            mem_access_size_q <= bus.req_size;
                            mem_rdun_q        <= 1'b1;
                            mem_data_in_q     <= bus.req_wdata;
                            mem_w_enable_q    <= bus.req_write;
                        end
`ifndef MISALIGN_TRAP_EN
                        else begin
                            state_q           <= SPLIT;
                            beat_q            <= 2'd0;
                            result_q          <= '0;
                            wdata_q           <= bus.req_wdata >> 8;
                            mem_address_q     <= bus.req_addr;
                            mem_access_size_q <= 2'b00;
                            mem_rdun_q        <= 1'b1;
                            mem_data_in_q     <= {24'b0, bus.req_wdata[7:0]};
                            mem_w_enable_q    <= bus.req_write;
                        end
`endif
                    end
                end

                ACCESS: begin
                    state_q           <= DONE;
                    mem_address_q     <= '0;
                    mem_data_in_q     <= '0;
                    mem_w_enable_q    <= 1'b0;
                    mem_access_size_q <= 2'b00;
                    mem_rdun_q        <= 1'b0;
                    resp_valid_q      <= 1'b1;
                    resp_err_q        <= 1'b0;
                    resp_rdata_q      <= write_q ? '0 : extend_load(bus.mem_data_out, size_q, unsigned_q);
                end

`ifndef MISALIGN_TRAP_EN
                SPLIT: begin
                    result_q <= split_merged;
                    if (beat_q == split_last) begin
                        state_q           <= DONE;
                        mem_address_q     <= '0;
                        mem_data_in_q     <= '0;
                        mem_w_enable_q    <= 1'b0;
                        mem_access_size_q <= 2'b00;
                        mem_rdun_q        <= 1'b0;
                        resp_valid_q      <= 1'b1;
                        resp_err_q        <= 1'b0;
                        resp_rdata_q      <= write_q ? '0 : extend_load(split_merged, size_q, unsigned_q);
                    end else begin
                        // wdata_q is consumed one byte per beat, lowest byte first
                        beat_q        <= beat_q + 2'd1;
                        wdata_q       <= wdata_q >> 8;
                        mem_address_q <= mem_address_q + 32'd1;
                        mem_data_in_q <= {24'b0, wdata_q[7:0]};
                    end
                end
`endif

                DONE: begin
                    state_q      <= IDLE;
                    req_ready_q  <= 1'b1;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= '0;
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready       = req_ready_q;
    assign bus.resp_valid      = resp_valid_q;
    assign bus.resp_err        = resp_err_q;
    assign bus.resp_rdata      = resp_rdata_q;
    assign bus.mem_address     = mem_address_q;
    assign bus.mem_data_in     = mem_data_in_q;
    assign bus.mem_w_enable    = mem_w_enable_q;
    assign bus.mem_access_size = mem_access_size_q;
    assign bus.mem_rdun        = mem_rdun_q;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Self-checking bench for lsu_mem_initiator: directed cases plus random traffic against
// a byte-array reference model of the memory window.
module tb_lsu_mem_initiator;

    localparam logic [31:0] START = 32'h0100_0000;
    localparam logic [31:0] SIZE  = 32'h0010_0000;
    localparam logic [31:0] WEND  = START + SIZE;
`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    lsu_mem_initiator_if bus();

    lsu_mem_initiator #(.START_ADDRESS(START), .MEM_SIZE(SIZE)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Only the bottom and top 256 bytes of the window are modelled.
    logic [7:0] mem_arr [0:511] = '{default: 8'h00};
    logic [7:0] ref_arr [0:511] = '{default: 8'h00};

    function automatic int midx(input logic [31:0] a);
        if (a >= START && a < START + 32'd256) return int'(a - START);
        if (a >= WEND - 32'd256 && a < WEND) return 256 + int'(a - (WEND - 32'd256));
        return -1;
    endfunction

    function automatic int size_bytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a, input logic [1:0] sz, input logic un);
        logic [31:0] v;
        int n;
        n = size_bytes(sz);
        v = '0;
        for (int i = 0; i < n; i++)
            if (midx(a + 32'(i)) >= 0) v[8*i +: 8] = mem_arr[midx(a + 32'(i))];
        if (!un && n < 4 && v[8*n-1]) v = v - (32'd1 << (8*n));
        return v;
    endfunction

    // Memory: combinational read modelled as settling by the falling edge, write on rising edge.
    always @(negedge clk)
        bus.mem_data_out <= mem_word(bus.mem_address, bus.mem_access_size, bus.mem_rdun);

    always @(posedge clk)
        if (bus.mem_w_enable === 1'b1)
            for (int i = 0; i < size_bytes(bus.mem_access_size); i++)
                if (midx(bus.mem_address + 32'(i)) >= 0)
                    mem_arr[midx(bus.mem_address + 32'(i))] <= bus.mem_data_in[8*i +: 8];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] got_data, output logic got_err, output int lat);
        int          n, beats, act, wait_cnt;
        logic [63:0] a64, last64;
        logic        range_err, mis, err;
        logic [31:0] exp_data;

        n         = size_bytes(sz);
        a64       = {32'b0, a};
        last64    = a64 + 64'(n) - 64'd1;
        range_err = (a64 < {32'b0, START}) || (last64 >= {32'b0, START} + {32'b0, SIZE});
        mis       = (a % n) != 0;
        err       = range_err || (TRAP && mis);
        beats     = err ? 0 : (mis ? n : 1);
        exp_data  = '0;
        if (!err && !wr) begin
            for (int i = 0; i < n; i++) exp_data[8*i +: 8] = ref_arr[midx(a + 32'(i))];
            if (!uns && n < 4 && exp_data[8*n-1]) exp_data = exp_data - (32'd1 << (8*n));
        end
        if (!err && wr)
            for (int i = 0; i < n; i++) ref_arr[midx(a + 32'(i))] = wd[8*i +: 8];

        wait_cnt = 0;
        @(negedge clk);
        while (bus.req_ready !== 1'b1 && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("req_ready_before_accept", 64'(bus.req_ready), 64'd1);
        bus.req_valid    = 1'b1;
        bus.req_write    = wr;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = a;
        bus.req_wdata    = wd;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;

        lat = 0;
        act = 0;
        got_data = 'x;
        got_err  = 1'bx;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            if (bus.resp_valid === 1'b1) begin
                lat      = cyc;
                got_data = bus.resp_rdata;
                got_err  = bus.resp_err;
                break;
            end
            check("beat_address", 64'(bus.mem_address), 64'(a + (mis ? 32'(act) : 32'd0)));
            check("beat_ctrl", {61'b0, bus.mem_access_size, bus.mem_w_enable},
                  {61'b0, (mis ? 2'b00 : sz), wr});
            check("beat_rdun", 64'(bus.mem_rdun), 64'd1);
            check("beat_wdata", 64'(bus.mem_data_in),
                  64'(mis ? {24'b0, wd[8*act +: 8]} : wd));
            act++;
            @(posedge clk);
            #1;
        end
        check("latency", 64'(lat), 64'(beats + 1));
        check("mem_beats", 64'(act), 64'(beats));
        check("resp_err", 64'(got_err), 64'(err));
        check("resp_rdata", 64'(got_data), 64'(exp_data));
        check("done_mem_idle", {31'b0, bus.mem_w_enable, bus.mem_address}, 64'd0);
        @(posedge clk);
        #1;
        check("resp_pulse_end", {62'b0, bus.resp_valid, bus.req_ready}, 64'd1);
    endtask

    initial begin : stim
        logic [31:0] rd;
        logic        er;
        int          lt;
        int          resp_seen;
        logic [31:0] ra;

        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;

        // Reset state
        #2 reset = 1'b1;
        #1;
        check("rst_req_ready", 64'(bus.req_ready), 64'd1);
        check("rst_resp", {31'b0, bus.resp_valid, bus.resp_err, bus.resp_rdata[30:0]}, 64'd0);
        check("rst_mem", {bus.mem_address, bus.mem_data_in[27:0], bus.mem_w_enable,
                          bus.mem_access_size, bus.mem_rdun}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Aligned store then load
        do_req(1'b1, 2'b10, 1'b0, 32'h0100_0010, 32'hDEAD_BEEF, rd, er, lt);
        check("t1_store_latency", 64'(lt), 64'd2);
        do_req(1'b0, 2'b10, 1'b0, 32'h0100_0010, 32'h0, rd, er, lt);
        check("t1_load_data", 64'(rd), 64'h0000_0000_DEAD_BEEF);

        // Byte / halfword sign and zero extension
        do_req(1'b0, 2'b00, 1'b0, 32'h0100_0011, 32'h0, rd, er, lt);
        check("t2_byte_signed", 64'(rd), 64'h0000_0000_FFFF_FFBE);
        do_req(1'b0, 2'b00, 1'b1, 32'h0100_0011, 32'h0, rd, er, lt);
        check("t2_byte_unsigned", 64'(rd), 64'h0000_0000_0000_00BE);
        do_req(1'b0, 2'b01, 1'b0, 32'h0100_0010, 32'h0, rd, er, lt);
        check("t2_half_signed", 64'(rd), 64'h0000_0000_FFFF_BEEF);

        // Misaligned word load
        for (int i = 0; i < 4; i++)
            do_req(1'b1, 2'b00, 1'b0, 32'h0100_0013 + 32'(i), 32'(8'h11 * (i + 1)), rd, er, lt);
        do_req(1'b0, 2'b10, 1'b0, 32'h0100_0013, 32'h0, rd, er, lt);
`ifndef MISALIGN_TRAP_EN
        check("t3_split_data", 64'(rd), 64'h0000_0000_4433_2211);
        check("t3_split_latency", 64'(lt), 64'd5);
`endif

        // Out of range
        do_req(1'b0, 2'b10, 1'b0, 32'h00FF_FFFC, 32'h0, rd, er, lt);
        check("t4_below_err", {31'b0, er, rd}, 64'h0000_0001_0000_0000);
        check("t4_below_latency", 64'(lt), 64'd1);
        do_req(1'b0, 2'b10, 1'b0, 32'h010F_FFFE, 32'h0, rd, er, lt);
        check("t4_top_err", 64'(er), 64'd1);

`ifndef MISALIGN_TRAP_EN
        // Reset during a split store, after two beats have been written
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_write    = 1'b1;
        bus.req_size     = 2'b10;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h0100_0021;
        bus.req_wdata    = 32'hAABB_CCDD;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        resp_seen = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (bus.resp_valid === 1'b1) resp_seen++;
        end
        reset = 1'b1;
        #1;
        check("t5_wen_async_drop", 64'(bus.mem_w_enable), 64'd0);
        ref_arr[midx(32'h0100_0021)] = 8'hDD;
        ref_arr[midx(32'h0100_0022)] = 8'hCC;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (bus.resp_valid === 1'b1) resp_seen++;
        end
        check("t5_no_response", 64'(resp_seen), 64'd0);
        check("t5_ready_after", 64'(bus.req_ready), 64'd1);
        for (int i = 0; i < 4; i++)
            check("t5_mem_bytes", 64'(mem_arr[midx(32'h0100_0021 + 32'(i))]),
                  64'(ref_arr[midx(32'h0100_0021 + 32'(i))]));
        check("t5_byte21", 64'(mem_arr[midx(32'h0100_0021)]), 64'hDD);
`endif

        // Misaligned halfword load
        do_req(1'b0, 2'b01, 1'b0, 32'h0100_0001, 32'h0, rd, er, lt);
        check("t6_misaligned_half_err", 64'(er), 64'(TRAP));

        // Random traffic, biased toward the window edges
        for (int t = 0; t < 150; t++) begin
            case ($urandom_range(0, 5))
                0:       ra = START - 32'($urandom_range(1, 4));
                1, 2:    ra = WEND - 32'($urandom_range(1, 8));
                default: ra = START + 32'($urandom_range(0, 60));
            endcase
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   ra, $urandom, rd, er, lt);
        end

        // Memory contents must match the model after all traffic
        for (int i = 0; i < 512; i += 7)
            check("final_mem", 64'(mem_arr[i]), 64'(ref_arr[i]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
